// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered N-to-2^N one-hot decoder with direct-select and auto-scan modes.
module onehot_scan_decoder #(
    parameter int SEL_W = 4,
    parameter int DWELL_W = 8,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               load,
    input  logic [SEL_W-1:0]   d_in,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   y_out,
    output logic [SEL_W-1:0]   sel_out,
    output logic               wrap
);
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
    state_t state, state_nxt;
    logic [SEL_W-1:0] idx_nxt;
    logic [DWELL_W-1:0] dwell_cnt, cnt_nxt;
    logic wrap_nxt;
    always_comb begin
        state_nxt = state;
        idx_nxt = load ? d_in : sel_out;
        cnt_nxt = '0;
        wrap_nxt = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            idx_nxt = sel_out;
        end else if (state == IDLE) begin
            state_nxt = mode ? SCAN : (load ? DIRECT : IDLE);
        end else if (!mode) begin
            state_nxt = DIRECT;
        end else begin
            state_nxt = SCAN;
            // >= so a dwell lowered under the running count advances at once
            if (state == SCAN && !load) begin
                if (dwell_cnt >= dwell) begin
                    idx_nxt = sel_out + 1'b1;
                    wrap_nxt = &sel_out;
                end else begin
                    cnt_nxt = dwell_cnt + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel_out <= '0;
            dwell_cnt <= '0;
            y_out <= '0;
            wrap <= 1'b0;
        end else begin
            state <= state_nxt;
            sel_out <= idx_nxt;
            dwell_cnt <= cnt_nxt;
            y_out <= (state_nxt == IDLE) ? '0 : OUT_W'(1) << idx_nxt;
            wrap <= wrap_nxt;
        end
    end
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb_onehot_scan_decoder: directed self-checking bench for onehot_scan_decoder (SEL_W=4, DWELL_W=8).
module tb_onehot_scan_decoder;
    logic clk = 1'b0;
    logic rst, en, mode, load;
    logic [3:0] d_in;
    logic [7:0] dwell;
    logic [15:0] y_out;
    logic [3:0] sel_out;
    logic wrap;
    int checks = 0;
    int failures = 0;
    int n;

    onehot_scan_decoder #(.SEL_W(4), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .d_in(d_in), .dwell(dwell), .y_out(y_out), .sel_out(sel_out), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] y, input logic [3:0] s, input logic w);
        check({tag, ".y"}, 32'(y_out), 32'(y));
        check({tag, ".sel"}, 32'(sel_out), 32'(s));
        check({tag, ".wrap"}, 32'(wrap), 32'(w));
    endtask

    initial begin
        rst = 1; en = 0; mode = 0; load = 0; d_in = 0; dwell = 0;
        step(); step();
        expect_out("reset", 16'h0000, 4'd0, 1'b0);
        rst = 0; en = 1; load = 1; d_in = 9;
        step();
        expect_out("direct9", 16'h0200, 4'd9, 1'b0);
        for (int i = 0; i < 16; i++) begin
            d_in = 4'(i);
            step();
            expect_out("sweep", 16'(1) << i, 4'(i), 1'b0);
        end
        // scan from 14 with hold of 3 cycles per channel
        mode = 1; d_in = 14; dwell = 2;
        step();
        load = 0;
        for (int i = 0; i < 3; i++) begin
            expect_out("scan14", 16'h4000, 4'd14, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            expect_out("scan15", 16'h8000, 4'd15, 1'b0);
            step();
        end
        expect_out("scanwrap", 16'h0001, 4'd0, 1'b1);
        n = 0;
        do begin
            step();
            n++;
        end while (!wrap && n < 200);
        check("period", 32'(n), 32'd48);
        check("period.y", 32'(y_out), 32'h0001);
        // dwell zero: advance every cycle, wrap every 16
        load = 1; d_in = 0; dwell = 0;
        step();
        load = 0;
        expect_out("dz_start", 16'h0001, 4'd0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            step();
            expect_out("dz", 16'(1) << (i % 16), 4'(i % 16), 1'(i % 16 == 0));
        end
        // load coinciding with dwell expiry at index 3
        load = 1; d_in = 3; dwell = 2;
        step();
        load = 0;
        step(); step();
        load = 1; d_in = 5;
        step();
        load = 0;
        expect_out("ld5", 16'h0020, 4'd5, 1'b0);
        step(); step();
        expect_out("ld5_hold", 16'h0020, 4'd5, 1'b0);
        step();
        expect_out("ld5_adv", 16'h0040, 4'd6, 1'b0);
        load = 1; d_in = 0;
        step();
        load = 0;
        expect_out("ld0_nowrap", 16'h0001, 4'd0, 1'b0);
        // dwell lowered below running count advances on the next cycle
        dwell = 5;
        step(); step(); step();
        dwell = 1;
        step();
        expect_out("dwell_low", 16'h0002, 4'd1, 1'b0);
        // enable drop and mode switch
        load = 1; d_in = 7; dwell = 2;
        step();
        load = 0; en = 0;
        step();
        expect_out("en_drop", 16'h0000, 4'd7, 1'b0);
        en = 1; mode = 0;
        step();
        expect_out("idle_hold", 16'h0000, 4'd7, 1'b0);
        mode = 1;
        step();
        expect_out("resume", 16'h0080, 4'd7, 1'b0);
        // reset while dwell expires at index 15
        load = 1; d_in = 15; dwell = 1;
        step();
        load = 0;
        step();
        rst = 1;
        step();
        expect_out("rst_mid", 16'h0000, 4'd0, 1'b0);
        rst = 0; en = 0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Registered, parametrised N-to-2^N one-hot decoder with a direct-select mode and an auto-scan mode. In auto-scan it steps the active output bit through every channel, holding each one for a programmable number of cycles. It is the successor to the fixed 4-to-16 enable-tree decoder. It drives channel-select and strobe lines (mux selects, row/segment enables) that must stay glitch-free and cycle-aligned.

## Interface
Parameters:
- SEL_W, default 4, select index width; output width is OUT_W = 2**SEL_W (derived localparam, not overridable).
- DWELL_W, default 8, width of the dwell-count input.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable; low forces outputs idle.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- load  input  1  one-cycle strobe; captures d_in as the new active index.
- d_in  input  SEL_W  select index / scan start index.
- dwell  input  DWELL_W  extra hold cycles per channel in scan mode (hold = dwell+1).
- y_out  output  OUT_W  registered one-hot output (all-zero when idle).
- sel_out  output  SEL_W  registered index of the active bit.
- wrap  output  1  one-cycle pulse when the scan wraps from OUT_W-1 to 0.

## Operation
- States: IDLE, DIRECT, SCAN. Registers: index (SEL_W), dwell_cnt (DWELL_W).
- Reset values: state = IDLE, y_out = 0, sel_out = 0, wrap = 0, dwell_cnt = 0.
- y_out is always 0 or exactly one-hot with bit sel_out set. There is no combinational path from inputs to outputs.

IDLE (y_out = 0):
- en=1, mode=0, load=1: index <= d_in, go DIRECT.
- en=1, mode=1: index <= (load ? d_in : sel_out), dwell_cnt <= 0, go SCAN.
- Otherwise stay in IDLE.

DIRECT:
- y_out = 1<<index.
- load=1: index <= d_in.
- mode=1: go SCAN from the current index (d_in if load=1 in the same cycle), dwell_cnt <= 0.

SCAN:
- y_out = 1<<index.
- dwell_cnt counts 0..dwell. When dwell_cnt == dwell, index advances by 1 modulo OUT_W and dwell_cnt <= 0.
- dwell is compared live each cycle. A dwell lowered below the current dwell_cnt advances the index on the next cycle.
- Wrap: when index goes OUT_W-1 -> 0, wrap = 1 in the same cycle y_out[0] first asserts.
- load=1: index <= d_in, dwell_cnt <= 0. This takes priority over the advance. No wrap pulse on a load, even to index 0.
- mode=0: go DIRECT holding the current index (d_in if load=1).

Global rules:
- en=0 in any state: next cycle state = IDLE, y_out = 0, wrap = 0, dwell_cnt = 0. sel_out keeps its last index.
- rst has priority over en, load and mode.
- dwell = 0 in SCAN: the index advances every cycle.

## Timing
- Latency: every input event (load, mode change, en rise/fall) is reflected in y_out/sel_out at the next rising clk edge (1 cycle).
- y_out, sel_out and wrap update on the same edge.
- In SCAN, each channel is active for exactly dwell+1 cycles, provided dwell does not change.
- A full scan period is OUT_W*(dwell+1) cycles.
- wrap is high for exactly 1 cycle per wrap.
- Reset asserted mid-scan: the outputs are at their reset values on the following edge, and no wrap pulse is generated.
- load and a dwell expiry in the same cycle: the load wins, dwell_cnt restarts at 0.

## Test plan
Use SEL_W=4, DWELL_W=8 throughout.
- Reset then direct decode: rst 2 cycles -> y_out = 0x0000, sel_out = 0. Then en=1, mode=0, load=1, d_in=9 -> next cycle y_out = 0x0200, sel_out = 9. Sweep all 16 indices -> one-hot exact each time.
- Scan with dwell: en=1, mode=1, load=1, d_in=14, dwell=2 -> y_out = 0x4000 for 3 cycles, then 0x8000 for 3 cycles, then 0x0001 with wrap=1 on that first cycle only. The period measures 48 cycles.
- Dwell zero: mode=1, dwell=0, start index 0 -> index increments every cycle, wrap pulses every 16 cycles.
- Load during scan: load d_in=5 on the same cycle dwell expires at index 3 -> next y_out = 0x0020, dwell restarts, no wrap pulse.
- Enable drop and mode switch: mid-scan at index 7, drop en -> next y_out = 0, sel_out = 7. Then en=1, mode=0 with no load -> stays y_out = 0 (IDLE). Then mode=1 -> resumes at 0x0080.
- Reset mid-scan: assert rst while at index 15 with dwell expiring -> y_out = 0, sel_out = 0, wrap = 0 on the next edge.
